// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: producer handshakes plus register file write port
interface regfile_write_arbiter_if #(parameter int N = 16, parameter int NREG = 8, parameter int AW = 3);
  logic req0_valid, req0_ready, req1_valid, req1_ready, write_enable, same_addr_conflict;
  logic [AW-1:0] req0_addr, req1_addr, write_addr;
  logic [N-1:0] req0_data, req1_data, write_data;
  logic [NREG-1:0] pending_mask;
  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input req0_ready, req1_ready, write_enable, write_addr, write_data, pending_mask, same_addr_conflict
  );
  modport slave (
    input req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, write_enable, write_addr, write_data, pending_mask, same_addr_conflict
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two one-entry slots drained onto the single register file write port
module regfile_write_arbiter #(parameter int N = 16, parameter int NREG = 8, parameter int AW = 3) (
  input logic clk,
  input logic rst,
  regfile_write_arbiter_if.slave bus
);
  logic [1:0] full;
  logic [AW-1:0] addr [2];
  logic [N-1:0] data [2];
  logic last_grant, older, same, grant0, grant1, acc0, acc1;
  // equal addresses drain oldest first so the younger value lands last
  always_comb begin
    same = &full && addr[0] == addr[1];
    grant1 = full[1] && (!full[0] || (same ? older : !last_grant));
    grant0 = full[0] && !grant1;
    acc0 = bus.req0_valid && (!full[0] || grant0);
    acc1 = bus.req1_valid && (!full[1] || grant1);
  end
  assign bus.req0_ready = !full[0] || grant0;
  assign bus.req1_ready = !full[1] || grant1;
  assign bus.write_enable = grant0 || grant1;
  assign bus.write_addr = grant0 ? addr[0] : grant1 ? addr[1] : '0;
  assign bus.write_data = grant0 ? data[0] : grant1 ? data[1] : '0;
  assign bus.same_addr_conflict = same;
  for (genvar r = 0; r < NREG; r++) begin : g_mask
    assign bus.pending_mask[r] = (full[0] && addr[0] == AW'(r)) || (full[1] && addr[1] == AW'(r));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
      addr[0] <= '0;
      addr[1] <= '0;
      data[0] <= '0;
      data[1] <= '0;
      last_grant <= 1'b1;
      older <= 1'b0;
    end else begin
      full <= {acc1 || (full[1] && !grant1), acc0 || (full[0] && !grant0)};
      if (acc0) begin
        addr[0] <= bus.req0_addr;
        data[0] <= bus.req0_data;
      end
      if (acc1) begin
        addr[1] <= bus.req1_addr;
        data[1] <= bus.req1_data;
      end
      if (grant0 || grant1) last_grant <= grant1;
      older <= acc0 && acc1 ? 1'b0 :
               acc0 && full[1] && !grant1 ? 1'b1 :
               acc1 && full[0] && !grant0 ? 1'b0 : older;
    end
  end
endmodule
